dmem_mmio: RTL and testbench



---
 rtl/dmem_pkg.sv | 36 +++
 rtl/dmem_ram.sv | 29 ++
 rtl/dmem_mmio.sv | 147 ++++++++++++++
 tb/tb_dmem_mmio.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg -- shared definitions for the A/D/M register and data-memory unit.
//   region_t        : address regions decoded from the A register
//   DEFAULT_IO_BASE : default first address of the memory-mapped I/O window
//   LED_OFFSET      : LED register offset inside the I/O window
//   SW_OFFSET       : switch input offset inside the I/O window
//   region_of()     : classifies an address against a given I/O base
// -----------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic [1:0] {
        REGION_RAM,
        REGION_LED,
        REGION_SW,
        REGION_NONE
    } region_t;

    localparam int unsigned DEFAULT_IO_BASE = 32'h0000_7F00;
    localparam int unsigned LED_OFFSET      = 0;
    localparam int unsigned SW_OFFSET       = 1;

    // Everything below io_base is RAM (aliased by the caller); inside the
    // window only the LED and switch slots are populated.
    function automatic region_t region_of(input logic [31:0] addr,
                                          input logic [31:0] io_base);
        if (addr < io_base)
            return REGION_RAM;
        else if (addr == io_base + LED_OFFSET)
            return REGION_LED;
        else if (addr == io_base + SW_OFFSET)
            return REGION_SW;
        else
            return REGION_NONE;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// -----------------------------------------------------------------------------
// dmem_ram -- single-port synchronous-read RAM (block-RAM inferable).
//   clk   : clock
//   we    : write enable
//   addr  : word address (read and write share it)
//   wdata : write data
//   rdata : registered read data (old contents on a same-edge write)
// Contents are not reset.
// -----------------------------------------------------------------------------
module dmem_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_mmio.sv
// -----------------------------------------------------------------------------
// dmem_mmio -- A and D registers plus data memory addressed by A, with a
// memory-mapped I/O window (LED register, optional switch input).
//   clk       : clock
//   rst       : synchronous active-high reset
//   reg_a_en  : load A from data_in
//   reg_d_en  : load D from data_in
//   reg_m_en  : write data_in to the address held in A before the edge
//   data_in   : ALU result bus
//   reg_a_out : current A
//   reg_d_out : current D
//   reg_m_out : registered read of the address captured on the last edge
//   m_valid   : reg_m_out belongs to the current A
//   leds      : LED register
//   sw_in     : switch inputs (only with DMEM_SW_IN_EN defined)
// Optional feature macro: DMEM_SW_IN_EN (switches readable at IO_BASE+1).
// -----------------------------------------------------------------------------
module dmem_mmio
    import dmem_pkg::*;
#(
    parameter int          DATA_W  = 16,
    parameter int          ADDR_W  = 13,
    parameter int unsigned IO_BASE = DEFAULT_IO_BASE,
    parameter int          LED_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_a_en,
    input  logic              reg_d_en,
    input  logic              reg_m_en,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] reg_a_out,
    output logic [DATA_W-1:0] reg_d_out,
    output logic [DATA_W-1:0] reg_m_out,
    output logic              m_valid,
`ifdef DMEM_SW_IN_EN
    output logic [LED_W-1:0]  leds,
    input  logic [15:0]       sw_in
`else
    output logic [LED_W-1:0]  leds
`endif
);

    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] d_reg;
    logic [LED_W-1:0]  leds_reg;
    logic [DATA_W-1:0] rd_addr_reg;
    logic [1:0]        init_reg;      // shift of ones after reset release
    logic              ram_sel_reg;   // output comes from the RAM port
    logic [DATA_W-1:0] io_data_reg;   // I/O read, constant 0 or forwarded write

    logic              ram_sel_next;
    logic [DATA_W-1:0] io_data_next;
    logic [DATA_W-1:0] sw_word;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_we;
    region_t           a_region;

    assign a_region = region_of(32'(a_reg), 32'(IO_BASE));

`ifdef DMEM_SW_IN_EN
    logic [15:0] sw_meta_reg;
    logic [15:0] sw_sync_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta_reg <= '0;
            sw_sync_reg <= '0;
        end else begin
            sw_meta_reg <= sw_in;
            sw_sync_reg <= sw_meta_reg;
        end
    end

    assign sw_word = DATA_W'(sw_sync_reg);
`else
    assign sw_word = '0;
`endif

    // Write goes to the A value present before the edge, even if A is being
    // reloaded on the same edge.
    assign ram_we = reg_m_en && !rst && (a_region == REGION_RAM);

    dmem_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (a_reg[ADDR_W-1:0]),
        .wdata (data_in),
        .rdata (ram_rdata)
    );

    // Read and write share the address, so a write simply forwards its own
    // data as the next read result; the RAM's stale read is bypassed.
    always_comb begin
        ram_sel_next = 1'b0;
        io_data_next = '0;
        case (a_region)
            REGION_RAM: begin
                if (reg_m_en)
                    io_data_next = data_in;
                else
                    ram_sel_next = 1'b1;
            end
            REGION_LED: begin
                if (reg_m_en)
                    io_data_next = DATA_W'(data_in[LED_W-1:0]);
                else
                    io_data_next = DATA_W'(leds_reg);
            end
            REGION_SW:   io_data_next = sw_word;
            default:     io_data_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg       <= '0;
            d_reg       <= '0;
            leds_reg    <= '0;
            rd_addr_reg <= '0;
            init_reg    <= '0;
            ram_sel_reg <= 1'b0;
            io_data_reg <= '0;
        end else begin
            if (reg_a_en)
                a_reg <= data_in;
            if (reg_d_en)
                d_reg <= data_in;
            if (reg_m_en && (a_region == REGION_LED))
                leds_reg <= data_in[LED_W-1:0];
            rd_addr_reg <= a_reg;
            init_reg    <= {init_reg[0], 1'b1};
            ram_sel_reg <= ram_sel_next;
            io_data_reg <= io_data_next;
        end
    end

    assign reg_a_out = a_reg;
    assign reg_d_out = d_reg;
    assign reg_m_out = ram_sel_reg ? ram_rdata : io_data_reg;
    assign m_valid   = init_reg[1] && (rd_addr_reg == a_reg);
    assign leds      = leds_reg;

endmodule

// File: tb/tb_dmem_mmio.sv
// -----------------------------------------------------------------------------
// tb_dmem_mmio -- directed bench for dmem_mmio with a reference model and an
// expected-value queue. Build with DMEM_SW_IN_EN to cover the switch input.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmem_mmio;

    localparam logic [15:0] IOB = 16'h7F00;
`ifdef DMEM_SW_IN_EN
    localparam bit SW_EN = 1'b1;
`else
    localparam bit SW_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_a_en, reg_d_en, reg_m_en;
    logic [15:0] data_in;
    logic [15:0] reg_a_out, reg_d_out, reg_m_out;
    logic        m_valid;
    logic [15:0] leds;
    logic [15:0] sw_val = 16'h0000;
`ifdef DMEM_SW_IN_EN
    logic [15:0] sw_in;
    assign sw_in = sw_val;
`endif

    always #5 clk = ~clk;

    dmem_mmio dut (
        .clk       (clk),
        .rst       (rst),
        .reg_a_en  (reg_a_en),
        .reg_d_en  (reg_d_en),
        .reg_m_en  (reg_m_en),
        .data_in   (data_in),
        .reg_a_out (reg_a_out),
        .reg_d_out (reg_d_out),
        .reg_m_out (reg_m_out),
        .m_valid   (m_valid),
`ifdef DMEM_SW_IN_EN
        .leds      (leds),
        .sw_in     (sw_in)
`else
        .leds      (leds)
`endif
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] leds;
        logic        valid;
        logic [15:0] m;
        bit          m_known;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // reference model state
    logic [15:0] mem_m [int];
    logic [15:0] m_a = 0, m_d = 0, m_leds = 0, m_rd = 0, m_m = 0;
    logic [15:0] sw1 = 0, sw2 = 0;
    int          m_init = 0;
    bit          m_known = 1'b1;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
        end
    endtask

    task automatic step(input bit r, input bit a_en, input bit d_en, input bit m_en,
                        input logic [15:0] din);
        exp_t        e;
        exp_t        got;
        logic [15:0] old_a;
        logic [15:0] sw_read;
        int          idx;
        rst = r; reg_a_en = a_en; reg_d_en = d_en; reg_m_en = m_en; data_in = din;
        old_a = m_a;
        if (r) begin
            m_a = 0; m_d = 0; m_leds = 0; m_rd = 0; m_m = 0; m_init = 0;
            m_known = 1'b1; sw1 = 0; sw2 = 0;
        end else begin
            sw_read = sw2;
            sw2 = sw1;
            sw1 = sw_val;
            if (old_a < IOB) begin
                idx = int'(old_a) % 8192;
                if (m_en) mem_m[idx] = din;
                if (mem_m.exists(idx)) begin
                    m_m = mem_m[idx]; m_known = 1'b1;
                end else begin
                    m_known = 1'b0;
                end
            end else if (old_a == IOB) begin
                if (m_en) m_leds = din;
                m_m = m_leds; m_known = 1'b1;
            end else if (old_a == IOB + 16'd1 && SW_EN) begin
                m_m = sw_read; m_known = 1'b1;
            end else begin
                m_m = 0; m_known = 1'b1;
            end
            m_rd = old_a;
            if (a_en) m_a = din;
            if (d_en) m_d = din;
            if (m_init < 2) m_init++;
        end
        e.a = m_a; e.d = m_d; e.leds = m_leds; e.m = m_m; e.m_known = m_known;
        e.valid = (m_init >= 2) && (m_rd == m_a);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        got = exp_q.pop_front();
        $display("cyc=%0d rst=%b a_en=%b d_en=%b m_en=%b din=%h -> A=%h D=%h M=%h v=%b leds=%h",
                 cyc, r, a_en, d_en, m_en, din, reg_a_out, reg_d_out, reg_m_out, m_valid, leds);
        chk("reg_a", reg_a_out, got.a);
        chk("reg_d", reg_d_out, got.d);
        chk("leds", leds, got.leds);
        chk("m_valid", {15'd0, m_valid}, {15'd0, got.valid});
        if (got.m_known) chk("reg_m", reg_m_out, got.m);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    initial begin
        // reset, then release
        step(1, 0, 0, 0, 16'h0000);
        step(1, 1, 1, 0, 16'h1111);
        step(1, 0, 0, 0, 16'h0000);
        idle(); idle(); idle();
        // A/D loads and RAM write/read
        step(0, 0, 1, 0, 16'h00D0);
        step(0, 1, 0, 0, 16'd5);
        step(0, 0, 0, 1, 16'hBEEF);
        step(0, 1, 0, 0, 16'd6);
        idle();
        step(0, 1, 0, 0, 16'd5);
        idle();
        // back-to-back forwarded writes
        step(0, 0, 0, 1, 16'h1234);
        step(0, 0, 0, 1, 16'h5678);
        idle();
        // write with same-cycle A reload uses old A
        step(0, 1, 0, 0, 16'd9);
        step(0, 0, 0, 1, 16'hC0DE);
        step(0, 1, 0, 0, 16'd5);
        idle();
        step(0, 1, 0, 1, 16'd9);
        idle();
        step(0, 1, 0, 0, 16'd5);
        idle();
        // reload A with its own value keeps m_valid
        step(0, 1, 0, 0, 16'd5);
        // LED register and empty I/O slot
        step(0, 1, 0, 0, IOB);
        step(0, 0, 0, 1, 16'h00A5);
        idle();
        step(0, 1, 0, 0, IOB + 16'd7);
        step(0, 0, 0, 1, 16'hFFFF);
        idle();
        // aliasing above 2**ADDR_W
        step(0, 1, 0, 0, 16'd3);
        step(0, 0, 0, 1, 16'h3333);
        step(0, 1, 0, 0, 16'd8195);
        idle();
        step(0, 0, 0, 1, 16'h4444);
        step(0, 1, 0, 0, 16'd3);
        idle();
        // reset overriding writes
        step(0, 1, 0, 0, 16'd0);
        step(0, 0, 0, 1, 16'hAAAA);
        step(0, 1, 0, 0, IOB);
        idle();
        step(1, 0, 0, 1, 16'h7777);
        step(1, 0, 0, 1, 16'h7777);
        idle(); idle(); idle();
        step(0, 1, 0, 0, IOB);
        idle();
        step(0, 1, 0, 0, IOB + 16'd1);
        step(0, 0, 0, 1, 16'h5A5A);
        idle();
        // switch input through the synchronizer
        sw_val = 16'h0F0F;
        idle(); idle(); idle();
        step(0, 1, 0, 0, 16'd5);
        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
